// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor move sequencer: FSM state codes, default
// timing constants and a small unsigned-min helper.
package motor_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RAMP   = 3'd2,
        ST_CRUISE = 3'd3,
        ST_SLOW   = 3'd4,
        ST_FAULT  = 3'd5
    } motor_state_t;

    localparam int DEF_RAMP_DIV     = 16000;
    localparam int DEF_RAMP_STEP    = 1;
    localparam int DEF_SLOW_TICKS   = 64;
    localparam int DEF_DUTY_SLOW    = 20;
    localparam int DEF_DEADTIME     = 1600;
    localparam int DEF_STALL_CYCLES = 1600000;

    function automatic logic [31:0] umin32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/duty_ramp.sv
// Ramp generator: a divider that steps a saturating duty accumulator by
// RAMP_STEP every RAMP_DIV enabled cycles, capped at limit.
module duty_ramp #(
    parameter int RAMP_DIV  = 16000,
    parameter int RAMP_STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic [31:0] duty,
    output logic [31:0] duty_nxt
);

    localparam logic [31:0] DIV_LAST = 32'(RAMP_DIV - 1);

    logic [31:0] div_q;
    logic [31:0] div_nxt;
    logic        armed_q;
    logic        armed_nxt;

    function automatic logic [31:0] step_sat(input logic [31:0] d, input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, d} + 33'(RAMP_STEP);
        return (sum >= {1'b0, lim}) ? lim : sum[31:0];
    endfunction

    // armed marks the first enabled cycle after a clear: the first step is
    // taken immediately so the output starts at min(RAMP_STEP, limit).
    always_comb begin
        duty_nxt  = duty;
        div_nxt   = div_q;
        armed_nxt = armed_q;
        if (clear) begin
            duty_nxt  = '0;
            div_nxt   = '0;
            armed_nxt = 1'b1;
        end else if (enable) begin
            if (armed_q) begin
                duty_nxt  = step_sat('0, limit);
                div_nxt   = '0;
                armed_nxt = 1'b0;
            end else if (div_q == DIV_LAST) begin
                duty_nxt = step_sat(duty, limit);
                div_nxt  = '0;
            end else begin
                div_nxt = div_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty    <= '0;
            div_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            duty    <= duty_nxt;
            div_q   <= div_nxt;
            armed_q <= armed_nxt;
        end
    end

endmodule

// File: rtl/motor_move_ctrl.sv
// Move sequencer for one drive motor: settle, ramp, cruise and slow approach
// on the selected pwm output, stopping on arrival, abort or encoder stall.
module motor_move_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int RAMP_DIV     = DEF_RAMP_DIV,
    parameter int RAMP_STEP    = DEF_RAMP_STEP,
    parameter int SLOW_TICKS   = DEF_SLOW_TICKS,
    parameter int DUTY_SLOW    = DEF_DUTY_SLOW,
    parameter int DEADTIME     = DEF_DEADTIME,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] target_ticks,
    input  logic        dir,
    input  logic [31:0] duty_max,
    input  logic [31:0] enc_count,
    output logic [31:0] pwm_fwd,
    output logic [31:0] pwm_bwd,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [2:0]  state
);

    localparam logic [31:0] SETTLE_LAST = 32'(DEADTIME - 1);
    localparam logic [31:0] STALL_LAST  = 32'(STALL_CYCLES - 1);
    localparam logic [31:0] SLOW_W      = 32'(SLOW_TICKS);
    localparam logic [31:0] DUTY_SLOW_W = 32'(DUTY_SLOW);

    // Handshake: start and abort are single-cycle strobes sampled on clk;
    // start is accepted only in IDLE/FAULT without abort, abort always wins.
    // done is a one-cycle strobe, busy and fault are levels.
    motor_state_t st, st_nxt;

    logic [31:0] tgt_q, dmax_q, base_q, enc_prev_q;
    logic        dir_q;
    logic [31:0] settle_cnt, stall_cnt;

    logic        start_acc, done_nxt;
    logic [31:0] travelled, remaining, drive_nxt;
    logic        arrived, near, enc_moved, stalled, driving;
    logic        ramp_en;
    logic [31:0] ramp_duty, ramp_duty_nxt;

    assign travelled = dir_q ? (enc_count - base_q) : (base_q - enc_count);
    assign remaining = tgt_q - travelled;
    assign arrived   = (travelled >= tgt_q);
    assign near      = (remaining <= SLOW_W);
    assign enc_moved = (enc_count != enc_prev_q);
    assign stalled   = (stall_cnt == STALL_LAST) && !enc_moved;
    assign driving   = (st == ST_RAMP) || (st == ST_CRUISE) || (st == ST_SLOW);
    assign ramp_en   = (st_nxt == ST_RAMP);
    assign state     = st;

    duty_ramp #(
        .RAMP_DIV (RAMP_DIV),
        .RAMP_STEP(RAMP_STEP)
    ) u_ramp (
        .clk     (clk),
        .reset   (reset),
        .clear   (!ramp_en),
        .enable  (ramp_en),
        .limit   (dmax_q),
        .duty    (ramp_duty),
        .duty_nxt(ramp_duty_nxt)
    );

    always_comb begin
        st_nxt    = st;
        start_acc = 1'b0;
        done_nxt  = 1'b0;
        if (abort) begin
            st_nxt = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        if (target_ticks == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            st_nxt = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) st_nxt = ST_RAMP;
                end
                ST_RAMP, ST_CRUISE, ST_SLOW: begin
                    // Arrival is checked first so an overshoot never detours via SLOW.
                    if (arrived) begin
                        st_nxt   = ST_IDLE;
                        done_nxt = 1'b1;
                    end else if (stalled) begin
                        st_nxt = ST_FAULT;
                    end else if (st != ST_SLOW && near) begin
                        st_nxt = ST_SLOW;
                    end else if (st == ST_RAMP && ramp_duty >= dmax_q) begin
                        st_nxt = ST_CRUISE;
                    end
                end
                ST_FAULT: begin
                    if (start) begin
                        start_acc = 1'b1;
                        st_nxt    = ST_SETTLE;
                    end
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        drive_nxt = '0;
        case (st_nxt)
            ST_RAMP:   drive_nxt = ramp_duty_nxt;
            ST_CRUISE: drive_nxt = dmax_q;
            ST_SLOW:   drive_nxt = umin32(DUTY_SLOW_W, dmax_q);
            default:   drive_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            tgt_q      <= '0;
            dmax_q     <= '0;
            base_q     <= '0;
            dir_q      <= 1'b0;
            enc_prev_q <= '0;
            settle_cnt <= '0;
            stall_cnt  <= '0;
            pwm_fwd    <= '0;
            pwm_bwd    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            st         <= st_nxt;
            enc_prev_q <= enc_count;
            if (start_acc) begin
                tgt_q  <= target_ticks;
                dmax_q <= duty_max;
                base_q <= enc_count;
                dir_q  <= dir;
            end
            settle_cnt <= (st == ST_SETTLE && st_nxt == ST_SETTLE) ? settle_cnt + 32'd1 : '0;
            // Watchdog runs only while driving; SETTLE exit leaves it at zero.
            stall_cnt  <= (driving && !enc_moved) ? stall_cnt + 32'd1 : '0;
            pwm_fwd    <= dir_q ? drive_nxt : '0;
            pwm_bwd    <= dir_q ? '0 : drive_nxt;
            busy       <= (st_nxt == ST_SETTLE) || (st_nxt == ST_RAMP) ||
                          (st_nxt == ST_CRUISE) || (st_nxt == ST_SLOW);
            done       <= done_nxt;
            fault      <= (st_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_motor_move_ctrl.sv
// Scoreboard bench for motor_move_ctrl with reduced timing: output events
// (pwm changes, done, fault changes) are predicted with their cycle stamps.
module tb_motor_move_ctrl;
  import motor_ctrl_pkg::*;

  localparam int RAMP_DIV     = 4;
  localparam int DEADTIME     = 8;
  localparam int STALL_CYCLES = 200;
  localparam int SLOW_TICKS   = 5;
  localparam int DUTY_SLOW    = 3;
  localparam int W            = 56;

  localparam logic [3:0] K_FWD   = 4'd1;
  localparam logic [3:0] K_BWD   = 4'd2;
  localparam logic [3:0] K_DONE  = 4'd3;
  localparam logic [3:0] K_FAULT = 4'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] target_ticks = '0;
  logic        dir = 1'b0;
  logic [31:0] duty_max = '0;
  logic [31:0] enc_count = 32'd1000;
  logic [31:0] pwm_fwd, pwm_bwd;
  logic        busy, done, fault;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int inv_errs = 0;
  logic mon_en = 1'b0;
  logic [31:0] prev_fwd = '0, prev_bwd = '0;
  logic prev_fault = 1'b0;
  logic [W-1:0] exp_q[$];

  motor_move_ctrl #(
    .RAMP_DIV(RAMP_DIV), .RAMP_STEP(1), .SLOW_TICKS(SLOW_TICKS),
    .DUTY_SLOW(DUTY_SLOW), .DEADTIME(DEADTIME), .STALL_CYCLES(STALL_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .target_ticks(target_ticks), .dir(dir), .duty_max(duty_max),
    .enc_count(enc_count), .pwm_fwd(pwm_fwd), .pwm_bwd(pwm_bwd),
    .busy(busy), .done(done), .fault(fault), .state(state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [31:0] v, input int c);
    logic [31:0] cc;
    cc = c;
    return {k, v, cc[19:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  task automatic check_evt(input logic [3:0] k, input logic [31:0] v);
    logic [W-1:0] act, exp;
    act = ev(k, v, cyc);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d val=%0h cyc=%0d, expected none", k, v, cyc);
    end else begin
      exp = exp_q.pop_front();
      if (exp !== act) begin
        failures++;
        $display("FAIL event: got kind=%0d val=%0h cyc=%0d, expected kind=%0d val=%0h cyc=%0d",
                 k, v, act[19:0], exp[55:52], exp[51:20], exp[19:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pwm_fwd != prev_fwd) check_evt(K_FWD, pwm_fwd);
      if (pwm_bwd != prev_bwd) check_evt(K_BWD, pwm_bwd);
      if (done) check_evt(K_DONE, 32'd1);
      if (fault != prev_fault) check_evt(K_FAULT, {31'b0, fault});
      if (pwm_fwd != 0 && pwm_bwd != 0) inv_errs++;
    end
    prev_fwd   = pwm_fwd;
    prev_bwd   = pwm_bwd;
    prev_fault = fault;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [31:0] t, input logic d, input logic [31:0] dm, output int n);
    @(posedge clk); #1;
    target_ticks = t; dir = d; duty_max = dm; start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic abort_pulse(input logic with_start, input logic [31:0] t, output int a);
    @(posedge clk); #1;
    abort = 1'b1; start = with_start; target_ticks = t;
    a = cyc;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
  endtask

  task automatic set_enc(input logic [31:0] v, output int e);
    @(posedge clk); #1;
    enc_count = v;
    e = cyc;
  endtask

  task automatic push_ramp(input logic [3:0] k, input int dm, input int n);
    for (int i = 1; i <= dm; i++)
      exp_q.push_back(ev(k, i, n + 1 + DEADTIME + RAMP_DIV * (i - 1)));
  endtask

  task automatic wait_drain(input string nm);
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk({nm, "_pending_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n, e, a, m;
    logic [31:0] base, v;

    // reset state
    tick(3);
    chk("rst_pwm_fwd", pwm_fwd, 0);
    chk("rst_pwm_bwd", pwm_bwd, 0);
    chk("rst_flags", {29'b0, busy, done, fault}, 0);
    chk("rst_state", state, 32'(ST_IDLE));
    reset = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // T1 forward move with ramp, cruise, slow approach, done
    base = enc_count;
    issue_start(20, 1'b1, 10, n);
    push_ramp(K_FWD, 10, n);
    for (int i = 1; i <= 20; i++) begin
      tick(9);
      set_enc(base + i, e);
      if (i == 2) chk("t1_busy", busy, 1);
      if (i == 15) exp_q.push_back(ev(K_FWD, DUTY_SLOW, e + 1));
      if (i == 20) begin
        exp_q.push_back(ev(K_FWD, 0, e + 1));
        exp_q.push_back(ev(K_DONE, 1, e + 1));
      end
    end
    wait_drain("t1");
    chk("t1_idle_state", state, 32'(ST_IDLE));
    chk("t1_busy_low", busy, 0);

    // T2 backward move across the 32-bit wrap
    set_enc(32'd3, e);
    tick(2);
    issue_start(10, 1'b0, 4, n);
    push_ramp(K_BWD, 4, n);
    for (int i = 1; i <= 10; i++) begin
      tick(9);
      v = 32'd3 - 32'(i);
      set_enc(v, e);
      if (i == 5) exp_q.push_back(ev(K_BWD, DUTY_SLOW, e + 1));
      if (i == 10) begin
        chk("t2_enc_end", enc_count, 32'hFFFF_FFF9);
        exp_q.push_back(ev(K_BWD, 0, e + 1));
        exp_q.push_back(ev(K_DONE, 1, e + 1));
      end
    end
    wait_drain("t2");

    // T3 stall -> FAULT, then restart clears fault, then abort
    issue_start(100, 1'b1, 2, n);
    push_ramp(K_FWD, 2, n);
    exp_q.push_back(ev(K_FWD, 0, n + 1 + DEADTIME + STALL_CYCLES));
    exp_q.push_back(ev(K_FAULT, 1, n + 1 + DEADTIME + STALL_CYCLES));
    wait_drain("t3_stall");
    chk("t3_fault", fault, 1);
    chk("t3_state", state, 32'(ST_FAULT));
    chk("t3_busy", busy, 0);
    issue_start(50, 1'b1, 1, m);
    exp_q.push_back(ev(K_FAULT, 0, m + 1));
    push_ramp(K_FWD, 1, m);
    tick(20);
    abort_pulse(1'b0, 50, a);
    exp_q.push_back(ev(K_FWD, 0, a + 1));
    wait_drain("t3_abort");
    chk("t3_abort_state", state, 32'(ST_IDLE));

    // T4 ignored start while busy, abort+start in CRUISE and in IDLE
    base = enc_count;
    issue_start(30, 1'b1, 2, n);
    push_ramp(K_FWD, 2, n);
    tick(20);
    issue_start(5, 1'b1, 7, m);
    set_enc(base + 8, e);
    tick(4);
    chk("t4_still_busy", busy, 1);
    chk("t4_cruise_state", state, 32'(ST_CRUISE));
    abort_pulse(1'b1, 5, a);
    exp_q.push_back(ev(K_FWD, 0, a + 1));
    tick(2);
    chk("t4_abort_state", state, 32'(ST_IDLE));
    abort_pulse(1'b1, 0, a);
    abort_pulse(1'b1, 12, a);
    tick(2);
    chk("t4_idle_abort_start", state, 32'(ST_IDLE));
    chk("t4_idle_busy", busy, 0);
    wait_drain("t4");

    // T5 zero target and overshoot
    issue_start(0, 1'b1, 5, n);
    exp_q.push_back(ev(K_DONE, 1, n + 1));
    tick(3);
    chk("t5_zero_state", state, 32'(ST_IDLE));
    base = enc_count;
    issue_start(20, 1'b1, 2, n);
    push_ramp(K_FWD, 2, n);
    tick(20);
    set_enc(base + 50, e);
    exp_q.push_back(ev(K_FWD, 0, e + 1));
    exp_q.push_back(ev(K_DONE, 1, e + 1));
    wait_drain("t5");

    // T6 asynchronous reset mid-RAMP
    issue_start(100, 1'b1, 5, n);
    push_ramp(K_FWD, 2, n);
    tick(14);
    #2;
    reset = 1'b1;
    exp_q.push_back(ev(K_FWD, 0, cyc));
    #1;
    chk("t6_pwm_fwd", pwm_fwd, 0);
    chk("t6_pwm_bwd", pwm_bwd, 0);
    chk("t6_flags", {29'b0, busy, done, fault}, 0);
    chk("t6_state", state, 32'(ST_IDLE));
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("t6_after_state", state, 32'(ST_IDLE));
    chk("t6_after_pwm", pwm_fwd, 0);
    wait_drain("t6");

    // final report
    chk("pwm_exclusive_violations", inv_errs, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
